coord_ascii_fmt: RTL and testbench
==================================

COORD_ASCII_FMT -- requirements
Module: coord_ascii_fmt

Interface
REQ-001 SHALL have parameter SEP, default 8'h2C (','), the byte emitted between the X and Y fields.
REQ-002 SHALL have parameter EOL_CR, default 1; 1 = emit CR before LF, 0 = LF only.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to sample x/y and emit one line.
REQ-006 SHALL have port x  input  8  two's-complement X coordinate from the position generator.
REQ-007 SHALL have port y  input  8  two's-complement Y coordinate.
REQ-008 SHALL have port tx_data  output  8  ASCII byte to the UART transmitter.
REQ-009 SHALL have port tx_valid  output  1  tx_data holds a valid byte.
REQ-010 SHALL have port tx_ready  input  1  UART transmitter accepts the byte this cycle.
REQ-011 SHALL have port busy  output  1  high from the start accept through the final byte transfer.

Function
REQ-012 SHALL emit per line: X field, SEP, Y field, [CR], LF.
REQ-013 SHALL format each field as signed decimal: '-' only if negative, magnitude with no leading zeros, value 0 as "0"; -128 -> "-128".
REQ-014 SHALL accept start only when busy=0, registering x and y in that same cycle; later x/y changes do not affect the line.
REQ-015 SHALL ignore start while busy=1: no queueing, no restart.
REQ-016 SHALL assert tx_valid with the first byte on the cycle after start is accepted.
REQ-017 SHALL count a byte as transferred on a cycle with tx_valid=1 and tx_ready=1; the next byte is presented on the following cycle, giving 1 byte/cycle with tx_ready held high.
REQ-018 SHALL hold tx_data and tx_valid stable while tx_valid=1 and tx_ready=0.
REQ-019 SHALL drop tx_valid and busy on the cycle after the LF transfer; start becomes acceptable on that same cycle.
REQ-020 SHALL sequence states IDLE -> [LBL_X] -> SIGN_X -> DIG_X -> SEP -> [LBL_Y] -> SIGN_Y -> DIG_Y -> [CR] -> LF -> IDLE.
REQ-021 SHALL skip SIGN_* when the value is non-negative and skip CR when EOL_CR=0.
REQ-022 SHALL iterate DIG_* over hundreds/tens/ones starting at the first nonzero digit, or at ones if the value is 0.
REQ-023 SHALL compute magnitude in 8 bits unsigned, with 0x80 -> 128 and no overflow.
REQ-024 SHALL never change tx_data while tx_valid=0 in a way visible to the handshake; tx_data is a don't-care when tx_valid=0.

Reset
REQ-025 SHALL, with rst=0 asynchronously, force state=IDLE, tx_valid=0, busy=0, tx_data=8'h00, and captured x/y=0.
REQ-026 SHALL abort any line in progress on reset mid-line without completing it; after release the block waits for a fresh start.

Configuration
REQ-027 SHALL, when macro COORD_FMT_LABEL_EN is defined, emit "X=" before the X field and "Y=" before the Y field (states LBL_X/LBL_Y, two bytes each).
REQ-028 SHALL, when COORD_FMT_LABEL_EN is undefined, contain no LBL states or logic, with line format per REQ-012.

Structure
REQ-029 SHALL place the ASCII constants ('0', '-', 'X', 'Y', '=', CR, LF) and the state enum typedef in shared package coord_fmt_pkg.
REQ-030 SHALL use one sub-module, s8_to_bcd: combinational 8-bit signed input -> neg flag, hundreds, tens, ones (4 bits each), digit count (1..3).
REQ-031 SHALL contain the FSM, byte mux and handshake in coord_ascii_fmt itself.

Verification
REQ-032 SHALL cover: x=8'hF6 (-10), y=0, start, tx_ready=1 -> bytes "-10,0\r\n" (2D 31 30 2C 30 0D 0A) on 7 consecutive cycles, first byte one cycle after start.
REQ-033 SHALL cover: x=8'h80, y=8'h7F -> "-128,127\r\n"; with EOL_CR=0 -> "-128,127\n".
REQ-034 SHALL cover: tx_ready toggled 0/1 every cycle for x=5, y=38 -> "5,38\r\n" with no dropped or duplicated bytes and tx_data stable during every stall.
REQ-035 SHALL cover: start re-pulsed mid-line with new x/y -> current line completes unchanged and no second line is emitted.
REQ-036 SHALL cover: rst asserted after the 3rd byte -> tx_valid=0 and busy=0 immediately; the next start emits a complete fresh line.
REQ-037 SHALL cover: with COORD_FMT_LABEL_EN defined, x=5, y=8'hFD (-3) -> "X=5,Y=-3\r\n".

Source files
------------

// File: rtl/coord_fmt_pkg.sv
// Shared constants and state encoding for the coordinate-to-ASCII line formatter.
// COORD_FMT_LABEL_EN adds the "X="/"Y=" label states.
package coord_fmt_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_X     = 8'h58;
  localparam logic [7:0] ASCII_Y     = 8'h59;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Digit index: 0 = hundreds, 1 = tens, 2 = ones.
  localparam logic [1:0] DIG_ONES = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SIGN_X = 4'd1,
    ST_DIG_X  = 4'd2,
    ST_SEP    = 4'd3,
    ST_SIGN_Y = 4'd4,
    ST_DIG_Y  = 4'd5,
    ST_CR     = 4'd6,
    ST_LF     = 4'd7
`ifdef COORD_FMT_LABEL_EN
    ,
    ST_LBL_X  = 4'd8,
    ST_LBL_Y  = 4'd9
`endif
  } state_t;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_0 + {4'h0, d};
  endfunction

  // Leading-zero suppression: start at hundreds, tens or ones depending on digit count.
  function automatic logic [1:0] first_digit(input logic [1:0] count);
    return 2'd3 - count;
  endfunction

endpackage

// File: rtl/s8_to_bcd.sv
// Combinational split of an 8-bit two's-complement value into sign, BCD digits
// and significant digit count (1..3).
module s8_to_bcd (
  input  logic [7:0] val,
  output logic       neg,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [1:0] count
);

  logic [7:0] mag;
  logic [7:0] rem;

  always_comb begin
    neg = val[7];
    // 0x80 negates to 0x80, which read unsigned is exactly 128.
    mag = val[7] ? (~val + 8'd1) : val;

    if (mag >= 8'd100) begin
      hundreds = 4'd1;
      rem      = mag - 8'd100;
    end else begin
      hundreds = 4'd0;
      rem      = mag;
    end

    tens = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (rem >= 8'(i * 10)) tens = 4'(i);
    end
    ones = 4'(rem - 8'(tens) * 8'd10);

    if (hundreds != 4'd0)  count = 2'd3;
    else if (tens != 4'd0) count = 2'd2;
    else                   count = 2'd1;
  end

endmodule

// File: rtl/coord_ascii_fmt.sv
// Formats a sampled (x, y) pair as one ASCII line "x,y[CR]LF" for a UART transmitter.
// COORD_FMT_LABEL_EN prefixes the fields with "X=" and "Y=".
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for start, tx_valid low
// LBL_X     | presenting 'X' then '=' (label build only)
// SIGN_X    | presenting '-' for negative x
// DIG_X     | presenting x digits, hundreds -> ones
// SEP       | presenting the separator byte
// LBL_Y     | presenting 'Y' then '=' (label build only)
// SIGN_Y    | presenting '-' for negative y
// DIG_Y     | presenting y digits
// CR        | presenting carriage return (EOL_CR = 1)
// LF        | presenting line feed, last byte of the line
module coord_ascii_fmt
  import coord_fmt_pkg::*;
#(
  parameter logic [7:0] SEP    = 8'h2C,
  parameter bit         EOL_CR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  state_t     state, state_nxt;
  logic [7:0] cx, cx_nxt;
  logic [7:0] cy, cy_nxt;
  logic [1:0] dig, dig_nxt;
`ifdef COORD_FMT_LABEL_EN
  logic       lbl, lbl_nxt;
`endif

  logic [7:0] bcd_in;
  logic       bcd_neg;
  logic [3:0] bcd_h, bcd_t, bcd_o;
  logic [1:0] bcd_cnt;
  logic [3:0] dig_val;

  // In IDLE the live x is converted so the first byte is known on the accept edge.
  always_comb begin
    case (state)
      ST_IDLE:                        bcd_in = x;
      ST_SEP, ST_SIGN_Y, ST_DIG_Y:    bcd_in = cy;
`ifdef COORD_FMT_LABEL_EN
      ST_LBL_Y:                       bcd_in = cy;
`endif
      default:                        bcd_in = cx;
    endcase
  end

  s8_to_bcd u_bcd (
    .val      (bcd_in),
    .neg      (bcd_neg),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .ones     (bcd_o),
    .count    (bcd_cnt)
  );

  always_comb begin
    state_nxt = state;
    cx_nxt    = cx;
    cy_nxt    = cy;
    dig_nxt   = dig;
`ifdef COORD_FMT_LABEL_EN
    lbl_nxt   = lbl;
`endif
    if (state == ST_IDLE) begin
      if (start) begin
        cx_nxt = x;
        cy_nxt = y;
`ifdef COORD_FMT_LABEL_EN
        state_nxt = ST_LBL_X;
        lbl_nxt   = 1'b0;
`else
        state_nxt = bcd_neg ? ST_SIGN_X : ST_DIG_X;
        dig_nxt   = first_digit(bcd_cnt);
`endif
      end
    end else if (tx_ready) begin
      case (state)
`ifdef COORD_FMT_LABEL_EN
        ST_LBL_X: begin
          if (lbl) begin
            state_nxt = bcd_neg ? ST_SIGN_X : ST_DIG_X;
            dig_nxt   = first_digit(bcd_cnt);
            lbl_nxt   = 1'b0;
          end else begin
            lbl_nxt = 1'b1;
          end
        end
        ST_LBL_Y: begin
          if (lbl) begin
            state_nxt = bcd_neg ? ST_SIGN_Y : ST_DIG_Y;
            dig_nxt   = first_digit(bcd_cnt);
            lbl_nxt   = 1'b0;
          end else begin
            lbl_nxt = 1'b1;
          end
        end
`endif
        ST_SIGN_X: state_nxt = ST_DIG_X;
        ST_DIG_X: begin
          if (dig == DIG_ONES) state_nxt = ST_SEP;
          else                 dig_nxt   = dig + 2'd1;
        end
        ST_SEP: begin
`ifdef COORD_FMT_LABEL_EN
          state_nxt = ST_LBL_Y;
          lbl_nxt   = 1'b0;
`else
          state_nxt = bcd_neg ? ST_SIGN_Y : ST_DIG_Y;
          dig_nxt   = first_digit(bcd_cnt);
`endif
        end
        ST_SIGN_Y: state_nxt = ST_DIG_Y;
        ST_DIG_Y: begin
          if (dig == DIG_ONES) state_nxt = EOL_CR ? ST_CR : ST_LF;
          else                 dig_nxt   = dig + 2'd1;
        end
        ST_CR:   state_nxt = ST_LF;
        ST_LF:   state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cx    <= 8'h00;
      cy    <= 8'h00;
      dig   <= 2'd0;
`ifdef COORD_FMT_LABEL_EN
      lbl   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cx    <= cx_nxt;
      cy    <= cy_nxt;
      dig   <= dig_nxt;
`ifdef COORD_FMT_LABEL_EN
      lbl   <= lbl_nxt;
`endif
    end
  end

  always_comb begin
    case (dig)
      2'd0:    dig_val = bcd_h;
      2'd1:    dig_val = bcd_t;
      default: dig_val = bcd_o;
    endcase
  end

  // Output byte depends only on registered state, so it holds through any stall.
  always_comb begin
    case (state)
`ifdef COORD_FMT_LABEL_EN
      ST_LBL_X:             tx_data = lbl ? ASCII_EQ : ASCII_X;
      ST_LBL_Y:             tx_data = lbl ? ASCII_EQ : ASCII_Y;
`endif
      ST_SIGN_X, ST_SIGN_Y: tx_data = ASCII_MINUS;
      ST_DIG_X, ST_DIG_Y:   tx_data = digit_char(dig_val);
      ST_SEP:               tx_data = SEP;
      ST_CR:                tx_data = ASCII_CR;
      ST_LF:                tx_data = ASCII_LF;
      default:              tx_data = 8'h00;
    endcase
  end

  assign tx_valid = (state != ST_IDLE);
  assign busy     = tx_valid;

endmodule

// File: tb/tb_coord_ascii_fmt.sv
// Self-checking bench for coord_ascii_fmt: directed corner lines plus random lines
// against a printf-based reference; a second instance covers EOL_CR = 0.
module tb_coord_ascii_fmt;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] x = 8'h00;
  logic [7:0] y = 8'h00;
  logic [7:0] d1, d2;
  logic       v1, v2, b1, b2;

  int checks = 0;
  int errors = 0;

  localparam int LIMIT = 200;

  always #5 clk = ~clk;

  coord_ascii_fmt dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .tx_data(d1), .tx_valid(v1), .tx_ready(tx_ready), .busy(b1)
  );

  coord_ascii_fmt #(.EOL_CR(1'b0)) dut_lf (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .tx_data(d2), .tx_valid(v2), .tx_ready(tx_ready), .busy(b2)
  );

  function automatic string model(input logic [7:0] xv, input logic [7:0] yv, input bit cr);
    string s;
    s = "";
`ifdef COORD_FMT_LABEL_EN
    s = "X=";
`endif
    s = {s, $sformatf("%0d", $signed(xv)), ","};
`ifdef COORD_FMT_LABEL_EN
    s = {s, "Y="};
`endif
    s = {s, $sformatf("%0d", $signed(yv))};
    if (cr) s = {s, "\r\n"};
    else    s = {s, "\n"};
    return s;
  endfunction

  function automatic string hexs(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed [%s] expected [%s]", tag, hexs(obs), hexs(exp));
    end
  endtask

  // Called at a negedge with both DUTs idle. mode: 0 ready held, 1 toggled, 2 random.
  task automatic run_line(input bit sel, input logic [7:0] xv, input logic [7:0] yv,
                          input int mode, input int repulse,
                          output string got, output int span,
                          output bit stable_ok, output bit idle_ok);
    logic       vo, bo;
    logic [7:0] dd, prev;
    bit         stalled;
    bit         busy_ok;
    int         cyc;
    got = ""; stalled = 1'b0; stable_ok = 1'b1; busy_ok = 1'b1; idle_ok = 1'b1;
    prev = 8'h00; cyc = 0;
    x = xv; y = yv; start = 1'b1; tx_ready = (mode == 0);
    @(negedge clk);
    start = 1'b0;
    x = 8'($urandom); y = 8'($urandom);
    while (cyc < LIMIT) begin
      vo = sel ? v2 : v1;
      dd = sel ? d2 : d1;
      bo = sel ? b2 : b1;
      if (vo !== 1'b1) break;
      if (bo !== 1'b1) busy_ok = 1'b0;
      if (stalled && dd !== prev) stable_ok = 1'b0;
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 2) == 1;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == repulse) begin
        start = 1'b1; x = 8'($urandom); y = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      if (tx_ready) got = $sformatf("%s%c", got, dd);
      stalled = !tx_ready;
      prev = dd;
      cyc++;
      @(negedge clk);
    end
    span = cyc;
    chk("line_bounded", 32'(cyc < LIMIT), 32'd1);
    chk("busy_tracks_valid", 32'(busy_ok), 32'd1);
    chk("busy_low_after_lf", 32'(sel ? b2 : b1), 32'd0);
    start = 1'b0; tx_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if ((sel ? v2 : v1) !== 1'b0) idle_ok = 1'b0;
    end
  endtask

  string      got, exp;
  int         span;
  bit         stable_ok, idle_ok;
  logic [7:0] ex [12];
  logic [7:0] xr, yr;
  bit         sel;

  initial begin
    // Reset state
    #1;
    chk("reset_valid", 32'(v1), 32'd0);
    chk("reset_busy", 32'(b1), 32'd0);
    chk("reset_data", 32'(d1), 32'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // -10,0 at full rate: 7 bytes on consecutive cycles, first one cycle after start
    run_line(1'b0, 8'hF6, 8'h00, 0, -1, got, span, stable_ok, idle_ok);
    chk_str("neg10_zero", got, "-10,0\r\n");
    chk("neg10_span", 32'(span), 32'd7);

    // Extremes with and without CR
    run_line(1'b0, 8'h80, 8'h7F, 0, -1, got, span, stable_ok, idle_ok);
    chk_str("min_max_crlf", got, model(8'h80, 8'h7F, 1'b1));
    run_line(1'b1, 8'h80, 8'h7F, 0, -1, got, span, stable_ok, idle_ok);
    chk_str("min_max_lf", got, "-128,127\n");

    // Toggling ready: no drops, no duplicates, stable data in stalls
    run_line(1'b0, 8'd5, 8'd38, 1, -1, got, span, stable_ok, idle_ok);
    chk_str("toggle_5_38", got, "5,38\r\n");
    chk("toggle_stable", 32'(stable_ok), 32'd1);

    // Start re-pulsed mid-line with new coordinates
    run_line(1'b0, 8'd12, 8'hD3, 0, 2, got, span, stable_ok, idle_ok);
    chk_str("repulse_line", got, "12,-45\r\n");
    chk("repulse_no_second", 32'(idle_ok), 32'd1);

    // Reset after the third byte
    x = 8'h9C; y = 8'h63; start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_line_active", 32'(v1), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(v1), 32'd0);
    chk("rst_mid_busy", 32'(b1), 32'd0);
    chk("rst_mid_data", 32'(d1), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(v1), 32'd0);
    run_line(1'b0, 8'hFB, 8'd7, 0, -1, got, span, stable_ok, idle_ok);
    chk_str("post_rst_line", got, model(8'hFB, 8'd7, 1'b1));

    // Label build line, or the plain equivalent otherwise
    run_line(1'b0, 8'd5, 8'hFD, 0, -1, got, span, stable_ok, idle_ok);
`ifdef COORD_FMT_LABEL_EN
    exp = "X=5,Y=-3\r\n";
`else
    exp = "5,-3\r\n";
`endif
    chk_str("label_5_m3", got, exp);

    // Digit-count boundaries
    ex = '{8'd0, 8'hFF, 8'd9, 8'd10, 8'd99, 8'h9D, 8'd100, 8'h9C, 8'd1, 8'hF7, 8'h7F, 8'h81};
    for (int i = 0; i < 12; i += 2) begin
      run_line(1'b0, ex[i], ex[i+1], 2, -1, got, span, stable_ok, idle_ok);
      chk_str($sformatf("edge_%0d", i / 2), got, model(ex[i], ex[i+1], 1'b1));
      chk($sformatf("edge_stable_%0d", i / 2), 32'(stable_ok), 32'd1);
    end

    // Random lines on either instance with random ready patterns
    for (int i = 0; i < 24; i++) begin
      sel = 1'($urandom_range(0, 1));
      xr = 8'($urandom); yr = 8'($urandom);
      run_line(sel, xr, yr, int'($urandom_range(0, 2)), -1, got, span, stable_ok, idle_ok);
      chk_str($sformatf("rand_%0d", i), got, model(xr, yr, !sel));
      chk($sformatf("rand_stable_%0d", i), 32'(stable_ok), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
